// File: rtl/dwc_sequencer.sv
// dwc_sequencer: pairs one result from each redundant core, runs the pair through the DWC comparator, then forwards, re-runs or faults.
// Latency: 3 cycles from the last capture to result_valid when the comparator answers in its first WAIT cycle.
// Backpressure: a core's ready drops once its word is captured; the result is held until result_ready. `DWC_TIMEOUT_EN builds the WAIT watchdog.
module dwc_sequencer #(
    parameter int DATA_W      = 32,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [31:0]       data_set,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [31:0]       isMatch,
    input  logic              interupt_match,
    output logic              rerun,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    input  logic              result_ready,
    output logic              fault,
    output logic [1:0]        fault_code,
    input  logic              clear_fault
);

    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [31:0] CMD_CMP  = 32'd3;
    localparam logic [1:0]  CODE_MIS = 2'b01;
    localparam logic [1:0]  CODE_TMO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_WAIT,
        S_OUT,
        S_RERUN,
        S_FAULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              a_cap;
    logic              b_cap;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [RCW-1:0]    retry_cnt;
    logic [1:0]        code_q;
    logic [1:0]        code_nxt;
    logic              a_hs;
    logic              b_hs;
    logic              clr_cap;
    logic              retry_inc;
    logic              retry_clr;
    logic              tmo_hit;
    logic              unused_bits;

    // Ready is gated by the reset pin so every output reads 0 while reset is held.
    assign a_ready      = reset && (state == S_IDLE) && !a_cap;
    assign b_ready      = reset && (state == S_IDLE) && !b_cap;
    assign a_hs         = a_valid && a_ready;
    assign b_hs         = b_valid && b_ready;
    assign data_set     = (state == S_CMP) ? CMD_CMP : 32'd0;
    assign data_a       = a_reg;
    assign data_b       = b_reg;
    assign rerun        = (state == S_RERUN);
    assign result_valid = (state == S_OUT);
    assign result_data  = (state == S_OUT) ? a_reg : '0;
    assign fault        = (state == S_FAULT);
    assign fault_code   = code_q;

`ifdef DWC_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] tmo_cnt;

    // Counts completed WAIT cycles; fires on the TIMEOUT_CYC-th silent one.
    assign tmo_hit = (tmo_cnt == TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state != S_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
        end
    end

    assign unused_bits = ^isMatch[31:1];
`else
    assign tmo_hit     = 1'b0;
    assign unused_bits = ^{isMatch[31:1], 32'(TIMEOUT_CYC), tmo_hit};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        clr_cap   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if ((a_cap || a_hs) && (b_cap || b_hs)) begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (interupt_match) begin
                    if (isMatch[0]) begin
                        state_nxt = S_OUT;
                    end else if (retry_cnt < RCW'(MAX_RETRY)) begin
                        state_nxt = S_RERUN;
                        retry_inc = 1'b1;
                    end else begin
                        state_nxt = S_FAULT;
                        code_nxt  = CODE_MIS;
                    end
                end
`ifdef DWC_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = S_FAULT;
                    code_nxt  = CODE_TMO;
                end
`endif
            end
            S_OUT: begin
                if (result_ready) begin
                    state_nxt = S_IDLE;
                    clr_cap   = 1'b1;
                    retry_clr = 1'b1;
                end
            end
            S_RERUN: begin
                state_nxt = S_IDLE;
                clr_cap   = 1'b1;
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_nxt = S_IDLE;
                    clr_cap   = 1'b1;
                    retry_clr = 1'b1;
                    code_nxt  = 2'b00;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_cap <= 1'b0;
            b_cap <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (clr_cap) begin
            a_cap <= 1'b0;
            b_cap <= 1'b0;
        end else begin
            if (a_hs) begin
                a_cap <= 1'b1;
                a_reg <= a_data;
            end
            if (b_hs) begin
                b_cap <= 1'b1;
                b_reg <= b_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_cnt <= '0;
            code_q    <= 2'b00;
        end else begin
            code_q <= code_nxt;
            if (retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RCW'(1);
            end
        end
    end

endmodule

// File: doc/dwc_sequencer.md
# dwc_sequencer

Initiator side of the duplication-with-comparison (DWC) check. Collects one result word from each of two redundant cores, drives the DWC comparator with the pair and the compare command (`data_set = 3`), and consumes its `interupt_match`/`isMatch` response. On a match it forwards the agreed result. On a mismatch it requests a core re-run, up to a retry limit, and then raises a sticky fault. Sits between the two core result ports and the DWC comparator instance.

## Interface
- `DATA_W`, 32: operand and result width.
- `MAX_RETRY`, 3: re-runs allowed per operation before a mismatch fault.
- `TIMEOUT_CYC`, 16: cycles in WAIT without a comparator response before a timeout fault.

- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `a_valid` in 1, `a_data` in DATA_W, `a_ready` out 1: core A result handshake.
- `b_valid` in 1, `b_data` in DATA_W, `b_ready` out 1: core B result handshake.
- `data_set` out 32: command to comparator; 3 = compare, 0 = idle.
- `data_a`, `data_b` out DATA_W: captured operands to comparator.
- `isMatch` in 32: comparator result; only bit 0 is used.
- `interupt_match` in 1: comparator response strobe.
- `rerun` out 1: one-cycle pulse requesting both cores to re-execute.
- `result_valid` out 1, `result_data` out DATA_W, `result_ready` in 1: checked-result handshake.
- `fault` out 1, `fault_code` out 2: sticky fault; 01 = persistent mismatch, 10 = timeout.
- `clear_fault` in 1: leaves FAULT.

## Operation
- Reset values:
  - all outputs 0;
  - captures empty;
  - `retry_cnt` 0 (width clog2(MAX_RETRY+1));
  - state IDLE.
- IDLE:
  - `a_ready` = 1 while A is not captured; `b_ready` = 1 while B is not captured.
  - A word is captured on `valid && ready`. A and B may arrive in any order or in the same cycle.
  - Once both are captured, go to CMP.
- CMP (one cycle): `data_set` = 3. Go to WAIT.
- WAIT:
  - `data_set` = 0; the timeout counter increments each cycle.
  - `interupt_match` && `isMatch[0]` → OUT.
  - `interupt_match` && !`isMatch[0]`:
    - if `retry_cnt` < MAX_RETRY → RERUN, `retry_cnt`++;
    - otherwise → FAULT with code 01.
  - Timeout counter reaches TIMEOUT_CYC → FAULT with code 10.
- OUT:
  - `result_valid` = 1 and `result_data` = captured A; both are held stable until `result_ready`.
  - On the handshake: clear captures, `retry_cnt` = 0, go to IDLE.
- RERUN (one cycle): `rerun` = 1, clear captures, keep `retry_cnt`, go to IDLE.
- FAULT:
  - `fault` = 1 and `fault_code` are held.
  - `a_ready`, `b_ready` and `result_valid` are 0.
  - `clear_fault` → IDLE with captures, `retry_cnt` and `fault_code` cleared.
- `data_a`/`data_b` always reflect the capture registers and stay stable from CMP through WAIT.
- `data_set` is 3 only in CMP.
- `clear_fault` outside FAULT is ignored.
- `interupt_match` outside WAIT is ignored.
- Only the decoded state changes `data_set`.

## Timing
- Cycle c: the last operand handshakes.
- c+1: CMP, `data_set` = 3.
- c+2: WAIT; a conforming comparator asserts `interupt_match` here.
- c+3: OUT (`result_valid` = 1) or RERUN (`rerun` = 1).
- Match latency is therefore 3 cycles from the last capture.
- A RERUN in cycle n makes `a_ready`/`b_ready` 1 in cycle n+1.
- The timeout fires on the TIMEOUT_CYC-th WAIT cycle that sees no `interupt_match`. With the default, that is WAIT cycle 16 (c+17), and FAULT is entered at c+18.
- Reset is asynchronous in any state, including mid-WAIT. It returns everything to reset values immediately, and any pending comparator response is ignored.

## Configuration
- `DWC_TIMEOUT_EN` defined:
  - the WAIT watchdog is built;
  - a missing response produces FAULT with code 10.
- `DWC_TIMEOUT_EN` not defined:
  - no counter is built;
  - WAIT waits indefinitely;
  - `fault_code` 10 is never produced;
  - `TIMEOUT_CYC` is unused.

## Test plan
- Match: A = B = 0x1234_5678 in the same cycle, comparator gives `isMatch` = 1 → `data_set` = 3 for exactly 1 cycle, `result_valid` at c+3 with 0x1234_5678, no `rerun`.
- Retry then pass: A = 5, B = 6 → one `rerun` pulse at c+3. Cores then resend A = B = 6 → result 6, with `retry_cnt` back to 0 after the handshake.
- Persistent mismatch (MAX_RETRY = 3): A ≠ B on every attempt → exactly 3 `rerun` pulses, then `fault` = 1 with `fault_code` = 01. `clear_fault` → IDLE with `a_ready` = `b_ready` = 1.
- Timeout (`DWC_TIMEOUT_EN`): `interupt_match` tied 0 → `fault_code` = 10 at c+18. With the macro undefined, the block stays in WAIT for 100 cycles with `fault` = 0.
- Backpressure and ordering: B arrives 4 cycles before A, and `result_ready` is held 0 for 5 cycles → `b_ready` is 0 after B's capture, and `result_valid`/`result_data` stay stable until `result_ready`.
- Reset mid-WAIT: `reset` = 0 asserted in c+2 → all outputs 0 asynchronously. After release, the block is in IDLE and a new match completes normally.
